// File: rtl/wb_exc_commit_pkg.sv
// Shared WB/CP0 definitions: bus width, exception codes, CP0 register numbers
// and the WB-stage instruction record.
package wb_exc_commit_pkg;

   localparam int WB_TO_CP0_REGISTER_BUS_WD = 110;

   localparam logic [4:0] EX_INT  = 5'd0;
   localparam logic [4:0] EX_ADEL = 5'd4;
   localparam logic [4:0] EX_ADES = 5'd5;
   localparam logic [4:0] EX_SYS  = 5'd8;
   localparam logic [4:0] EX_BP   = 5'd9;
   localparam logic [4:0] EX_RI   = 5'd10;
   localparam logic [4:0] EX_OV   = 5'd12;

   localparam logic [4:0] CR_BADVADDR = 5'd8;
   localparam logic [4:0] CR_COUNT    = 5'd9;
   localparam logic [4:0] CR_COMPARE  = 5'd11;
   localparam logic [4:0] CR_STATUS   = 5'd12;
   localparam logic [4:0] CR_CAUSE    = 5'd13;
   localparam logic [4:0] CR_EPC      = 5'd14;

   typedef enum logic {
      ST_RUN,
      ST_DRAIN
   } state_e;

   // One instruction as held in the WB register; int_tag is the interrupt
   // folded in at acceptance time.
   typedef struct packed {
      logic        int_tag;
      logic        ex;
      logic [4:0]  excode;
      logic [31:0] badvaddr;
      logic        bd;
      logic [31:0] pc;
      logic        mtc0;
      logic        eret;
      logic [4:0]  c0_addr;
      logic [31:0] rt_value;
   } ws_instr_t;

   function automatic logic is_addr_exc(input logic [4:0] code);
      return (code == EX_ADEL) || (code == EX_ADES);
   endfunction

endpackage

// File: rtl/wb_exc_commit_prio.sv
// Combinational commit resolver: interrupt > carried exception > ERET > MTC0,
// packed onto the WB-to-CP0 bus. Every field is zero when nothing commits.
module wb_exc_commit_prio
   import wb_exc_commit_pkg::*;
(
   input  logic                                 valid_i,
   input  ws_instr_t                            instr_i,
   output logic [WB_TO_CP0_REGISTER_BUS_WD-1:0] bus_o,
   output logic                                 ex_o,
   output logic                                 eret_o
);

   logic        ex;
   logic [4:0]  excode;
   logic [31:0] badvaddr;
   logic        bd;
   logic [31:0] pc;
   logic        mtc0_we;
   logic [4:0]  c0_waddr;
   logic [31:0] c0_wdata;
   logic        eret_flush;

   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      ex         = 1'b0;
      excode     = '0;
      badvaddr   = '0;
      bd         = 1'b0;
      pc         = '0;
      mtc0_we    = 1'b0;
      c0_waddr   = '0;
      c0_wdata   = '0;
      eret_flush = 1'b0;

      if (valid_i) begin
         ex = instr_i.int_tag | instr_i.ex;
         bd = instr_i.bd;
         pc = instr_i.pc;
         if (ex) begin
            excode = instr_i.int_tag ? EX_INT : instr_i.excode;
            if (is_addr_exc(excode)) begin
               badvaddr = instr_i.badvaddr;
            end
         end else if (instr_i.eret) begin
            eret_flush = 1'b1;
         end else if (instr_i.mtc0) begin
            mtc0_we  = 1'b1;
            c0_waddr = instr_i.c0_addr;
            c0_wdata = instr_i.rt_value;
         end
      end
   end

   assign bus_o  = {ex, excode, badvaddr, bd, pc, mtc0_we, c0_waddr, c0_wdata, eret_flush};
   assign ex_o   = ex;
   assign eret_o = eret_flush;

endmodule

// File: rtl/wb_exc_commit.sv
// Writeback commit controller: WB register with interrupt tagging, CP0 bus
// driver, flush/redirect generation and the post-flush drain FSM.
module wb_exc_commit
   import wb_exc_commit_pkg::*;
#(
   parameter logic [31:0] EX_ENTRY     = 32'hBFC0_0380,
   parameter int unsigned DRAIN_CYCLES = 3
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 ms_to_ws_valid,
   output logic                                 ws_allowin,
   input  logic                                 ms_ex,
   input  logic [4:0]                           ms_excode,
   input  logic [31:0]                          ms_badvaddr,
   input  logic                                 ms_bd,
   input  logic [31:0]                          ms_pc,
   input  logic                                 ms_mtc0,
   input  logic                                 ms_eret,
   input  logic [4:0]                           ms_c0_addr,
   input  logic [31:0]                          ms_rt_value,
   input  logic                                 c0_status_ie,
   input  logic                                 c0_status_exl,
   input  logic [7:0]                           c0_status_im,
   input  logic [7:0]                           c0_cause_ip,
   input  logic [31:0]                          c0_epc,
   output logic [WB_TO_CP0_REGISTER_BUS_WD-1:0] wb_to_cp0_bus,
   output logic                                 flush,
   output logic [31:0]                          flush_pc
);

   localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

   state_e    state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic      ws_valid_q, ws_valid_d;
   ws_instr_t ws_q, ws_d;

   logic int_pending;
   logic accept;
   logic commit_valid;
   logic commit_ex;
   logic commit_eret;

   assign int_pending = c0_status_ie & ~c0_status_exl & (|(c0_status_im & c0_cause_ip));

   assign ws_allowin = ~reset & (state_q == ST_RUN);
   assign accept     = ms_to_ws_valid & ws_allowin;

   // Gating with reset keeps the bus quiet during the reset cycle itself.
   assign commit_valid = ws_valid_q & ~reset;

   wb_exc_commit_prio u_prio (
      .valid_i (commit_valid),
      .instr_i (ws_q),
      .bus_o   (wb_to_cp0_bus),
      .ex_o    (commit_ex),
      .eret_o  (commit_eret)
   );

   assign flush    = commit_ex | commit_eret;
   assign flush_pc = flush ? (commit_ex ? EX_ENTRY : c0_epc) : '0;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_RUN: begin
            if (flush) begin
               state_d = ST_DRAIN;
               cnt_d   = DRAIN_LOAD;
            end
         end
         ST_DRAIN: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_RUN;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   // The instruction accepted in the flush cycle belongs to the wrong path.
   assign ws_valid_d = accept & ~flush;

   always_comb begin
      ws_d = ws_q;
      if (accept) begin
         ws_d = '{int_tag:  int_pending,
                  ex:       ms_ex,
                  excode:   ms_excode,
                  badvaddr: ms_badvaddr,
                  bd:       ms_bd,
                  pc:       ms_pc,
                  mtc0:     ms_mtc0,
                  eret:     ms_eret,
                  c0_addr:  ms_c0_addr,
                  rt_value: ms_rt_value};
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_RUN;
         cnt_q      <= '0;
         ws_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ws_valid_q <= ws_valid_d;
      end
   end

   // NOTE: the payload register is not reset; ws_valid_q qualifies it.
   always_ff @(posedge clk) begin
      ws_q <= ws_d;
   end

endmodule
